// File: rtl/pipeline_types.sv
// pipeline_types: shared pipeline parameters and the Dispatch-to-RS issue packet.
package pipeline_types;
  localparam int RS_DEPTH_DEFAULT = 8;
  localparam int PREG_W = 6;
  localparam int ROB_W = 5;
  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_LSU = 2'd1,
    FU_BR  = 2'd2
  } fu_type_t;
  typedef struct packed {
    fu_type_t          fu_type;
    logic [3:0]        alu_op;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic [PREG_W-1:0] rs1_p;
    logic [PREG_W-1:0] rs2_p;
    logic [PREG_W-1:0] rd_p;
    logic [ROB_W-1:0]  rob_tag;
    logic [31:0]       imm;
    logic [31:0]       pc;
  } rs_issue_packet_t;
endpackage

// File: rtl/rs_age_matrix.sv
// rs_age_matrix: relative age of RS entries and one-hot grant of the oldest eligible entry.
module rs_age_matrix
  import pipeline_types::*;
#(
  parameter int DEPTH = RS_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alloc_valid_i,
  input  logic [$clog2(DEPTH)-1:0] alloc_idx_i,
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH-1:0]         eligible_i,
  output logic [DEPTH-1:0]         grant_o
);
  // age_q[i][j]=1: entry i is older than entry j
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
  always_comb begin
    age_d = age_q;
    if (alloc_valid_i) begin
      for (int j = 0; j < DEPTH; j++) begin
        age_d[alloc_idx_i][j] = 1'b0;
        age_d[j][alloc_idx_i] = valid_i[j];
      end
    end
  end
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_o[i] = eligible_i[i];
      for (int j = 0; j < DEPTH; j++)
        if (eligible_i[j] && age_q[j][i]) grant_o[i] = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) age_q <= '0;
    else age_q <= age_d;
endmodule

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: reservation station with CDB wakeup and oldest-first issue to one FU.
module rs_issue_scheduler
  import pipeline_types::*;
#(
  parameter int DEPTH  = RS_DEPTH_DEFAULT,
  parameter int PREG_W = pipeline_types::PREG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   disp_valid_i,
  input  rs_issue_packet_t       disp_pkt_i,
  input  logic                   disp_rs1_rdy_i,
  input  logic                   disp_rs2_rdy_i,
  output logic                   rs_ready_o,
  input  logic                   cdb_valid_i,
  input  logic [PREG_W-1:0]      cdb_tag_i,
  output logic                   issue_valid_o,
  output rs_issue_packet_t       issue_pkt_o,
  input  logic                   fu_ready_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] occupancy_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  logic [DEPTH-1:0] valid_q, valid_d, rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
  logic [DEPTH-1:0] eligible, grant;
  rs_issue_packet_t pkt_q [DEPTH];
  rs_issue_packet_t pkt_d [DEPTH];
  logic [CW-1:0] occ_q, occ_d;
  logic [IW-1:0] alloc_idx, grant_idx;
  logic alloc, fire, cdb_live, cap_rs1, cap_rs2;
  function automatic logic [IW-1:0] lowest_set(input logic [DEPTH-1:0] m);
    lowest_set = '0;
    for (int i = DEPTH - 1; i >= 0; i--) if (m[i]) lowest_set = IW'(i);
  endfunction
  assign rs_ready_o    = occ_q < CW'(DEPTH);
  assign occupancy_o   = occ_q;
  assign eligible      = valid_q & rs1_rdy_q & rs2_rdy_q;
  assign issue_valid_o = |eligible;
  assign grant_idx     = lowest_set(grant);
  assign issue_pkt_o   = pkt_q[grant_idx];
  assign fire          = issue_valid_o && fu_ready_i;
  assign alloc         = disp_valid_i && rs_ready_o && !flush_i;
  assign alloc_idx     = lowest_set(~valid_q);
  assign cdb_live      = cdb_valid_i && cdb_tag_i != '0;
  // same-cycle CDB bypass so a broadcast coinciding with dispatch is not lost
  assign cap_rs1 = disp_rs1_rdy_i || disp_pkt_i.rs1_p == '0 ||
                   (cdb_valid_i && cdb_tag_i == disp_pkt_i.rs1_p);
  assign cap_rs2 = disp_rs2_rdy_i || disp_pkt_i.rs2_p == '0 ||
                   (cdb_valid_i && cdb_tag_i == disp_pkt_i.rs2_p) ||
                   (disp_pkt_i.alu_src && !disp_pkt_i.mem_write);
  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_valid_i(alloc),
    .alloc_idx_i  (alloc_idx),
    .valid_i      (valid_q),
    .eligible_i   (eligible),
    .grant_o      (grant)
  );
  always_comb begin
    valid_d   = valid_q;
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    pkt_d     = pkt_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_live && pkt_q[i].rs1_p == cdb_tag_i) rs1_rdy_d[i] = 1'b1;
      if (cdb_live && pkt_q[i].rs2_p == cdb_tag_i) rs2_rdy_d[i] = 1'b1;
      if (fire && grant[i]) valid_d[i] = 1'b0;
      if (alloc && alloc_idx == IW'(i)) begin
        valid_d[i]   = 1'b1;
        pkt_d[i]     = disp_pkt_i;
        rs1_rdy_d[i] = cap_rs1;
        rs2_rdy_d[i] = cap_rs2;
      end
    end
    if (flush_i) valid_d = '0;
  end
  assign occ_d = flush_i ? '0 : occ_q + CW'(alloc) - CW'(fire);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      occ_q     <= '0;
      for (int i = 0; i < DEPTH; i++) pkt_q[i] <= '0;
    end else begin
      valid_q   <= valid_d;
      rs1_rdy_q <= rs1_rdy_d;
      rs2_rdy_q <= rs2_rdy_d;
      occ_q     <= occ_d;
      pkt_q     <= pkt_d;
    end
  end
  // Dispatch must respect rs_ready_o; a write while full is dropped
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(disp_valid_i && !rs_ready_o))
    else $error("rs_issue_scheduler: dispatch while full");
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: directed and random stimulus against an age-ordered queue model.
module tb_rs_issue_scheduler;
  import pipeline_types::*;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic disp_valid_i = 1'b0, disp_rs1_rdy_i = 1'b0, disp_rs2_rdy_i = 1'b0;
  logic cdb_valid_i = 1'b0, fu_ready_i = 1'b0, flush_i = 1'b0;
  logic [5:0] cdb_tag_i = '0;
  rs_issue_packet_t disp_pkt_i = '0;
  rs_issue_packet_t issue_pkt_o;
  logic rs_ready_o, issue_valid_o;
  logic [3:0] occupancy_o;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    rs_issue_packet_t p;
    bit r1;
    bit r2;
  } ent_t;
  ent_t q[$];
  always #5 clk = ~clk;
  rs_issue_scheduler #(.DEPTH(DEPTH), .PREG_W(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .disp_valid_i  (disp_valid_i),
    .disp_pkt_i    (disp_pkt_i),
    .disp_rs1_rdy_i(disp_rs1_rdy_i),
    .disp_rs2_rdy_i(disp_rs2_rdy_i),
    .rs_ready_o    (rs_ready_o),
    .cdb_valid_i   (cdb_valid_i),
    .cdb_tag_i     (cdb_tag_i),
    .issue_valid_o (issue_valid_o),
    .issue_pkt_o   (issue_pkt_o),
    .fu_ready_i    (fu_ready_i),
    .flush_i       (flush_i),
    .occupancy_o   (occupancy_o)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic rs_issue_packet_t mk(input int rob, input logic [5:0] r1, input logic [5:0] r2,
                                          input logic src, input logic mw);
    rs_issue_packet_t p;
    p.fu_type   = fu_type_t'(2'($urandom_range(0, 2)));
    p.alu_op    = 4'($urandom);
    p.alu_src   = src;
    p.mem_read  = 1'($urandom);
    p.mem_write = mw;
    p.rs1_p     = r1;
    p.rs2_p     = r2;
    p.rd_p      = 6'($urandom);
    p.rob_tag   = 5'(rob);
    p.imm       = $urandom;
    p.pc        = $urandom;
    return p;
  endfunction
  // One cycle: drive inputs, check outputs against the model, advance the model, cross the edge
  task automatic step(input bit dv, input rs_issue_packet_t p, input bit d1, input bit d2,
                      input bit cv, input logic [5:0] tag, input bit fr, input bit fl);
    int sel;
    bit full;
    ent_t e;
    disp_valid_i = dv; disp_pkt_i = p; disp_rs1_rdy_i = d1; disp_rs2_rdy_i = d2;
    cdb_valid_i = cv; cdb_tag_i = tag; fu_ready_i = fr; flush_i = fl;
    sel = -1;
    for (int i = 0; i < q.size(); i++) if (sel < 0 && q[i].r1 && q[i].r2) sel = i;
    chk("issue_valid", issue_valid_o, sel >= 0);
    if (sel >= 0) chk("issue_pkt", issue_pkt_o, q[sel].p);
    chk("occupancy", occupancy_o, q.size());
    chk("rs_ready", rs_ready_o, q.size() < DEPTH);
    full = q.size() == DEPTH;
    if (fl) q.delete();
    else begin
      if (sel >= 0 && fr) q.delete(sel);
      if (cv && tag != 0)
        foreach (q[i]) begin
          if (q[i].p.rs1_p == tag) q[i].r1 = 1;
          if (q[i].p.rs2_p == tag) q[i].r2 = 1;
        end
      if (dv && !full) begin
        e.p  = p;
        e.r1 = d1 || p.rs1_p == 0 || (cv && tag == p.rs1_p);
        e.r2 = d2 || p.rs2_p == 0 || (cv && tag == p.rs2_p) || (p.alu_src && !p.mem_write);
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n, input bit fr);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0, fr, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_issue_valid", issue_valid_o, 0);
    chk("reset_occupancy", occupancy_o, 0);
    chk("reset_rs_ready", rs_ready_o, 1);
    chk("reset_issue_pkt", issue_pkt_o, 0);
    rst_n = 1'b1;
    // fill in order, hold the FU, then drain oldest-first
    for (int k = 0; k < 8; k++) step(1, mk(k, 6'(k + 1), 6'(k + 9), 0, 0), 1, 1, 0, 0, 0, 0);
    idle(1, 0);
    idle(10, 1);
    // A waits on tag 12, younger B overtakes, A wakes next cycle
    step(1, mk(8, 12, 0, 0, 0), 0, 1, 0, 0, 1, 0);
    step(1, mk(9, 3, 4, 0, 0), 1, 1, 0, 0, 1, 0);
    step(0, '0, 0, 0, 1, 12, 1, 0);
    idle(3, 1);
    // dispatch coinciding with the producing broadcast
    step(1, mk(10, 20, 0, 0, 0), 0, 1, 1, 20, 1, 0);
    idle(3, 1);
    // full with FU stalled, then wake and drain
    for (int k = 0; k < 8; k++) step(1, mk(11 + k, 6'(30 + k), 6'(50 + k), 1, 0), k % 2, 0, 0, 0, 0, 0);
    idle(3, 0);
    for (int k = 0; k < 8; k++) step(0, '0, 0, 0, 1, 6'(30 + k), 1, 0);
    idle(10, 1);
    // flush at occupancy 5 with a simultaneous dispatch; later CDB must not revive entries
    for (int k = 0; k < 5; k++) step(1, mk(20 + k, 6'(40 + k), 0, 0, 0), 0, 1, 0, 0, 0, 0);
    step(1, mk(25, 1, 2, 0, 0), 1, 1, 0, 0, 1, 1);
    for (int k = 0; k < 5; k++) step(0, '0, 0, 0, 1, 6'(40 + k), 1, 0);
    // asynchronous reset in the middle of a cycle
    for (int k = 0; k < 3; k++) step(1, mk(26 + k, 5, 6, 0, 0), 1, 1, 0, 0, 0, 0);
    idle(1, 0);
    disp_valid_i = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("async_issue_valid", issue_valid_o, 0);
    chk("async_occupancy", occupancy_o, 0);
    chk("async_rs_ready", rs_ready_o, 1);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // random traffic with a small tag space for frequent wakeups
    for (int n = 0; n < 600; n++) begin
      bit dv, fl;
      fl = $urandom_range(0, 40) == 0;
      dv = q.size() < DEPTH && $urandom_range(0, 1) == 1;
      step(dv, mk(n, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 1'($urandom), 1'($urandom)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
           6'($urandom_range(0, 7)), $urandom_range(0, 2) != 0, fl);
    end
    idle(2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
